// File: rtl/sample_window_buffer_if.sv
// Sample/tap-read bus for sample_window_buffer.
// master: quantiser/MAC sequencer side (drives samples and tap reads).
// slave : the history buffer itself.
interface sample_window_buffer_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic              mode;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_offset;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              new_sample;
  logic              ovf;

  modport master (
    output mode, in_valid, in_data, rd_en, rd_offset,
    input  in_ready, rd_valid, rd_data, count, full, new_sample, ovf
  );

  modport slave (
    input  mode, in_valid, in_data, rd_en, rd_offset,
    output in_ready, rd_valid, rd_data, count, full, new_sample, ovf
  );
endinterface

// File: rtl/sample_window_buffer.sv
// sample_window_buffer: circular history of the last DEPTH samples with
// tap-indexed read x[n-k] (1-cycle latency, zero outside the held history).
// Optional overwrite tracking enabled by defining SAMPLE_WINDOW_BUFFER_OVF_EN.
module sample_window_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input logic                  clk,
  input logic                  rst,
  sample_window_buffer_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W-1:0] rd_addr;
  logic              full_w;
  logic              accept;
  logic              tap_hit;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              new_sample_q;

  // Acceptance: circular mode always takes samples, one-shot stalls when full.
  assign full_w       = (count_q == DEPTH_C);
  assign bus.in_ready = bus.mode | ~full_w;
  assign accept       = bus.in_valid & bus.in_ready;

  // Tap address wraps naturally in ADDR_W bits; taps beyond the history read 0.
  assign rd_addr = wr_ptr - ADDR_W'(1) - bus.rd_offset;
  assign tap_hit = ({1'b0, bus.rd_offset} < count_q);

  // Sample storage, left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= bus.in_data;
  end

  // Write pointer and occupancy; occupancy saturates at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (accept) begin
      wr_ptr <= wr_ptr + ADDR_W'(1);
      if (!full_w) count_q <= count_q + (ADDR_W+1)'(1);
    end
  end

  // Tap read: uses pre-write pointer/count, so a same-cycle write is not visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) rd_data_q <= tap_hit ? mem[rd_addr] : '0;
    end
  end

  // One-cycle notification after each accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) new_sample_q <= 1'b0;
    else     new_sample_q <= accept;
  end

`ifdef SAMPLE_WINDOW_BUFFER_OVF_EN
  logic ovf_q;

  // Sticky flag: set once any sample has overwritten the oldest entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             ovf_q <= 1'b0;
    else if (accept && full_w && bus.mode) ovf_q <= 1'b1;
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.count      = count_q;
  assign bus.full       = full_w;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.new_sample = new_sample_q;
endmodule

// File: tb/tb_sample_window_buffer.sv
// Scoreboard bench for sample_window_buffer: a queue-based history model
// predicts tap reads; a monitor pops predictions whenever rd_valid is seen.
module tb_sample_window_buffer;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);
`ifdef SAMPLE_WINDOW_BUFFER_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sample_window_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  sample_window_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: hist[0] is the newest sample.
  int hist[$];
  int exp_q[$];
  bit m_ovf    = 1'b0;
  bit exp_ns   = 1'b0;
  bit exp_rv   = 1'b0;
  int rd_hold  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every presented tap read against the oldest prediction.
  always @(negedge clk) begin
    if (!rst && bus.rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got rd_valid=1 expected no pending read at %0t", $time);
      end else begin
        chk("rd_data", int'(bus.rd_data), exp_q.pop_front());
      end
    end
  end

  // One cycle of stimulus; entered and left at posedge+1.
  task automatic step(input bit m, input bit v, input int d, input bit re, input int off);
    int  cnt;
    bit  acc;
    bus.mode      = m;
    bus.in_valid  = v;
    bus.in_data   = DATA_W'(d);
    bus.rd_en     = re;
    bus.rd_offset = ADDR_W'(off);
    @(negedge clk);
    cnt = hist.size();
    chk("in_ready",   int'(bus.in_ready),   int'(m || cnt < DEPTH));
    chk("count",      int'(bus.count),      cnt);
    chk("full",       int'(bus.full),       int'(cnt == DEPTH));
    chk("new_sample", int'(bus.new_sample), int'(exp_ns));
    chk("ovf",        int'(bus.ovf),        int'(m_ovf));
    chk("rd_valid",   int'(bus.rd_valid),   int'(exp_rv));
    if (!exp_rv) chk("rd_hold", int'(bus.rd_data), rd_hold);
    if (re) begin
      rd_hold = (off < cnt) ? hist[off] : 0;
      exp_q.push_back(rd_hold);
    end
    acc = v && (m || cnt < DEPTH);
    if (acc) begin
      if (cnt == DEPTH && OVF_EN) m_ovf = 1'b1;
      hist.push_front(d & 8'hFF);
      if (hist.size() > DEPTH) void'(hist.pop_back());
    end
    exp_ns = acc;
    exp_rv = re;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset mid-cycle with a read request pending.
  task automatic do_reset();
    bus.rd_en    = 1'b1;
    bus.in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_rd_valid",   int'(bus.rd_valid),   0);
    chk("rst_rd_data",    int'(bus.rd_data),    0);
    chk("rst_count",      int'(bus.count),      0);
    chk("rst_full",       int'(bus.full),       0);
    chk("rst_new_sample", int'(bus.new_sample), 0);
    chk("rst_ovf",        int'(bus.ovf),        0);
    bus.rd_en    = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    hist.delete();
    exp_q.delete();
    m_ovf   = 1'b0;
    exp_ns  = 1'b0;
    exp_rv  = 1'b0;
    rd_hold = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.mode = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    bus.rd_en = 1'b0; bus.rd_offset = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: one-shot, four samples, taps 0..4
    for (int i = 1; i <= 4; i++) step(0, 1, i, 0, 0);
    for (int k = 0; k <= 4; k++) step(0, 0, 0, 1, k);
    step(0, 0, 0, 0, 0);

    // 2: fill in one-shot mode, extra samples held off
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(0, 1, i + 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 8'hEE, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    // 3: circular overwrite of DEPTH+3 samples
    do_reset();
    for (int i = 0; i < DEPTH + 3; i++) step(1, 1, i + 1, 0, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, DEPTH - 1);
    step(1, 0, 0, 0, 0);

    // 4: same-cycle write and read
    do_reset();
    step(0, 1, 8'h55, 0, 0);
    step(0, 1, 8'hAA, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    // 5: reset mid-stream with a read pending
    for (int i = 0; i < 5; i++) step(1, 1, 8'h30 + i, 1, i);
    step(1, 0, 0, 0, 0);
    do_reset();
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    // Randomised traffic with mode switches and occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        step(bus.mode, 0, 0, 0, 0);
        do_reset();
      end else begin
        step(($urandom_range(0, 3) != 0) ? bus.mode : 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 2) != 0), int'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)));
      end
    end

    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("pending_reads", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
